// File: rtl/cdb_arbiter.sv
// cdb_arbiter: common-data-bus arbiter for the Tomasulo core.
//
// Each functional unit (index 1..FU_NUM) raises a one-cycle fu_done pulse with
// its result. The result is parked in a per-index slot. Exactly one valid slot
// is granted per cycle. The grant is broadcast one cycle later on the
// registered CDB outputs. Index 0 is reserved and is never captured or granted.
//
// Build option:
//   CDB_RR_EN  defined   -> round-robin arbitration with a rotating pointer
//              undefined -> fixed priority, lowest valid index wins
//
// Ports:
//   clk, rst           core clock; synchronous active-high reset
//   fu_done[i]         finish pulse from FU i (bit 0 ignored)
//   fu_data[32i+:32]   result of FU i
//   fu_rd[5i+:5]       destination register of FU i
//   fu_wb[i]           1 = result writes the register file
//   fu_ready[i]        slot i accepts a finish pulse this cycle
//   CDB_result         registered one-hot grant
//   CDB_data/CDB_addr  broadcast data / destination register
//   register_write_en  register-file write strobe (0 for rd == x0)
//   register_to_write  register-file write address (same as CDB_addr)
//   overflow           sticky: a finish pulse was dropped
module cdb_arbiter #(
  parameter int FU_NUM = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [FU_NUM:0]            fu_done,
  input  logic [32*(FU_NUM+1)-1:0]   fu_data,
  input  logic [5*(FU_NUM+1)-1:0]    fu_rd,
  input  logic [FU_NUM:0]            fu_wb,
  output logic [FU_NUM:0]            fu_ready,
  output logic [FU_NUM:0]            CDB_result,
  output logic [31:0]                CDB_data,
  output logic [4:0]                 CDB_addr,
  output logic                       register_write_en,
  output logic [4:0]                 register_to_write,
  output logic                       overflow
);

  localparam int IDX_W = $clog2(FU_NUM + 1);

  logic [FU_NUM:1] valid_q, valid_d;
  logic [31:0]     data_q [1:FU_NUM];
  logic [31:0]     data_d [1:FU_NUM];
  logic [4:0]      rd_q   [1:FU_NUM];
  logic [4:0]      rd_d   [1:FU_NUM];
  logic [FU_NUM:1] wb_q, wb_d;

  logic            overflow_q, overflow_d;
  logic [FU_NUM:0] cdb_result_q, cdb_result_d;
  logic [31:0]     cdb_data_q, cdb_data_d;
  logic [4:0]      cdb_addr_q, cdb_addr_d;
  logic            reg_wen_q, reg_wen_d;

  logic             grant_found;
  logic [IDX_W-1:0] grant_idx;
  logic [FU_NUM:1]  grant_vec;
  logic [FU_NUM:1]  slot_ready;

  // Index 0 inputs exist only to keep the bus layout uniform.
  logic unused_idx0;
  assign unused_idx0 = ^{fu_done[0], fu_data[31:0], fu_rd[4:0], fu_wb[0]};

`ifdef CDB_RR_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;

  // Search starts at the pointer and wraps from FU_NUM back to 1.
  always_comb begin
    int cand;
    cand        = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < FU_NUM; k++) begin
      cand = int'(ptr_q) + k;
      if (cand > FU_NUM) cand = cand - FU_NUM;
      if (!grant_found && valid_q[cand]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_found) begin
      ptr_d = (grant_idx == IDX_W'(FU_NUM)) ? IDX_W'(1) : grant_idx + IDX_W'(1);
    end
  end
`else
  // Scan from the top down so the lowest valid index is the last one written.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = FU_NUM; i >= 1; i--) begin
      if (valid_q[i]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(i);
      end
    end
  end
`endif

  always_comb begin
    grant_vec = '0;
    for (int i = 1; i <= FU_NUM; i++) begin
      grant_vec[i] = grant_found && (grant_idx == IDX_W'(i));
    end
  end

  // A slot being granted this cycle frees up in time to take a new result.
  assign slot_ready = ~valid_q | grant_vec;
  assign fu_ready   = {slot_ready, 1'b0};

  always_comb begin
    valid_d    = valid_q & ~grant_vec;
    data_d     = data_q;
    rd_d       = rd_q;
    wb_d       = wb_q;
    overflow_d = overflow_q;
    for (int i = 1; i <= FU_NUM; i++) begin
      if (fu_done[i]) begin
        if (slot_ready[i]) begin
          valid_d[i] = 1'b1;
          data_d[i]  = fu_data[32*i +: 32];
          rd_d[i]    = fu_rd[5*i +: 5];
          wb_d[i]    = fu_wb[i];
        end else begin
          overflow_d = 1'b1;
        end
      end
    end
  end

  // Data/addr hold on idle cycles so snoopers see a stable bus.
  always_comb begin
    cdb_result_d = {grant_vec, 1'b0};
    cdb_data_d   = cdb_data_q;
    cdb_addr_d   = cdb_addr_q;
    reg_wen_d    = 1'b0;
    if (grant_found) begin
      cdb_data_d = data_q[grant_idx];
      cdb_addr_d = rd_q[grant_idx];
      reg_wen_d  = wb_q[grant_idx] && (rd_q[grant_idx] != 5'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= '0;
      data_q       <= '{default: '0};
      rd_q         <= '{default: '0};
      wb_q         <= '0;
      overflow_q   <= 1'b0;
      cdb_result_q <= '0;
      cdb_data_q   <= '0;
      cdb_addr_q   <= '0;
      reg_wen_q    <= 1'b0;
`ifdef CDB_RR_EN
      ptr_q        <= IDX_W'(1);
`endif
    end else begin
      valid_q      <= valid_d;
      data_q       <= data_d;
      rd_q         <= rd_d;
      wb_q         <= wb_d;
      overflow_q   <= overflow_d;
      cdb_result_q <= cdb_result_d;
      cdb_data_q   <= cdb_data_d;
      cdb_addr_q   <= cdb_addr_d;
      reg_wen_q    <= reg_wen_d;
`ifdef CDB_RR_EN
      ptr_q        <= ptr_d;
`endif
    end
  end

  assign CDB_result        = cdb_result_q;
  assign CDB_data          = cdb_data_q;
  assign CDB_addr          = cdb_addr_q;
  assign register_write_en = reg_wen_q;
  assign register_to_write = cdb_addr_q;
  assign overflow          = overflow_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: directed scenarios plus randomized traffic,
// checked against a slot/queue-level reference model of the arbiter.
module tb_cdb_arbiter;
  localparam int N = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N:0]           fu_done, fu_wb, fu_ready, CDB_result;
  logic [32*(N+1)-1:0]  fu_data;
  logic [5*(N+1)-1:0]   fu_rd;
  logic [31:0]          CDB_data;
  logic [4:0]           CDB_addr, register_to_write;
  logic                 register_write_en, overflow;

  logic        in_done [1:N];
  logic [31:0] in_data [1:N];
  logic [4:0]  in_rd   [1:N];
  logic        in_wb   [1:N];
  logic        junk0;

  // Reference model state
  bit          m_valid [1:N];
  logic [31:0] m_data  [1:N];
  logic [4:0]  m_rd    [1:N];
  bit          m_wb    [1:N];
  int          m_ptr;
  bit          m_ovf;
  logic [N:0]  e_result;
  logic [31:0] e_data;
  logic [4:0]  e_addr;
  bit          e_wen;

  int n_cmp, n_err;
  bit armed;

  cdb_arbiter #(.FU_NUM(N)) dut (
    .clk(clk), .rst(rst),
    .fu_done(fu_done), .fu_data(fu_data), .fu_rd(fu_rd), .fu_wb(fu_wb),
    .fu_ready(fu_ready), .CDB_result(CDB_result), .CDB_data(CDB_data),
    .CDB_addr(CDB_addr), .register_write_en(register_write_en),
    .register_to_write(register_to_write), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always_comb begin
    fu_done = '0;
    fu_wb   = '0;
    fu_data = '0;
    fu_rd   = '0;
    fu_done[0]    = junk0;
    fu_wb[0]      = junk0;
    fu_data[31:0] = {32{junk0}};
    fu_rd[4:0]    = {5{junk0}};
    for (int i = 1; i <= N; i++) begin
      fu_done[i]         = in_done[i];
      fu_wb[i]           = in_wb[i];
      fu_data[32*i +: 32] = in_data[i];
      fu_rd[5*i +: 5]    = in_rd[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int m_winner();
`ifdef CDB_RR_EN
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr - 1 + k) % N + 1;
      if (m_valid[i]) return i;
    end
`else
    for (int i = 1; i <= N; i++) if (m_valid[i]) return i;
`endif
    return 0;
  endfunction

  task automatic clear_inputs();
    for (int i = 1; i <= N; i++) begin
      in_done[i] = 1'b0; in_data[i] = '0; in_rd[i] = '0; in_wb[i] = 1'b0;
    end
  endtask

  task automatic put(input int i, input logic [31:0] d, input logic [4:0] r, input logic w);
    in_done[i] = 1'b1; in_data[i] = d; in_rd[i] = r; in_wb[i] = w;
  endtask

  // One clock: check readiness before the edge, advance the model at the edge,
  // check registered outputs just after it.
  task automatic tick();
    int w;
    logic [N:1] rdy;
    w = m_winner();
    for (int i = 1; i <= N; i++) rdy[i] = !m_valid[i] || (i == w);
    @(negedge clk);
    if (armed) begin
      check("fu_ready", fu_ready[N:1], rdy);
      check("overflow_pre", overflow, m_ovf);
    end
    @(posedge clk);
    if (rst) begin
      for (int i = 1; i <= N; i++) begin
        m_valid[i] = 0; m_data[i] = '0; m_rd[i] = '0; m_wb[i] = 0;
      end
      m_ptr = 1; m_ovf = 0;
      e_result = '0; e_data = '0; e_addr = '0; e_wen = 0;
    end else begin
      e_result = '0;
      e_wen    = 0;
      if (w != 0) begin
        e_result[w] = 1'b1;
        e_data      = m_data[w];
        e_addr      = m_rd[w];
        e_wen       = m_wb[w] && (m_rd[w] != 0);
        m_valid[w]  = 0;
        m_ptr       = (w == N) ? 1 : w + 1;
      end
      for (int i = 1; i <= N; i++) begin
        if (in_done[i]) begin
          if (rdy[i]) begin
            m_valid[i] = 1; m_data[i] = in_data[i]; m_rd[i] = in_rd[i]; m_wb[i] = in_wb[i];
          end else begin
            m_ovf = 1;
          end
        end
      end
    end
    #1;
    armed = 1;
    check("cdb_result", CDB_result, e_result);
    check("cdb_data", CDB_data, e_data);
    check("cdb_addr", CDB_addr, e_addr);
    check("reg_to_write", register_to_write, e_addr);
    check("reg_wen", register_write_en, e_wen);
    check("overflow", overflow, m_ovf);
    check("onehot", $onehot0(CDB_result), 1);
  endtask

  initial begin
    int cnt7, nb, prev, seen;
    n_cmp = 0; n_err = 0; armed = 0; junk0 = 1'b0;
    m_ptr = 1; m_ovf = 0;
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_result", CDB_result, 0);
    check("rst_data", CDB_data, 0);
    check("rst_addr", CDB_addr, 0);
    check("rst_wen", register_write_en, 0);
    check("rst_ovf", overflow, 0);

    // Single result, two-cycle latency
    put(1, 32'h0000_00AA, 5'd5, 1'b1);
    tick();
    clear_inputs();
    tick();
    check("single_grant", CDB_result, 32'h002);
    check("single_data", CDB_data, 32'hAA);
    check("single_addr", CDB_addr, 5);
    check("single_wen", register_write_en, 1);
    tick();
    check("single_gone", CDB_result, 0);

    // Contention between slots 3 and 6
    put(3, 32'h33, 5'd3, 1'b1);
    put(6, 32'h66, 5'd6, 1'b1);
    tick();
    clear_inputs();
    tick();
    check("cont_first", CDB_result, 32'h008);
    check("cont_first_data", CDB_data, 32'h33);
    tick();
    check("cont_second", CDB_result, 32'h040);
    check("cont_second_data", CDB_data, 32'h66);
    tick();

    // Fairness: keep slots 1, 2 and 7 refilled whenever they can accept
    cnt7 = 0; prev = 0;
    for (int c = 0; c < 12; c++) begin
      int w;
      w = m_winner();
      clear_inputs();
      if (!m_valid[1] || w == 1) put(1, 32'h100 + c, 5'd1, 1'b1);
      if (!m_valid[2] || w == 2) put(2, 32'h200 + c, 5'd2, 1'b1);
      if (!m_valid[7] || w == 7) put(7, 32'h700 + c, 5'd7, 1'b1);
      tick();
      if (CDB_result[7]) cnt7++;
      if (CDB_result != 0) begin
        int g;
        g = $clog2(CDB_result);
`ifdef CDB_RR_EN
        if (prev != 0) check("rr_order", g, (prev == 1) ? 2 : (prev == 2) ? 7 : 1);
`else
        check("fixed_order", g, 1);
`endif
        prev = g;
      end
    end
`ifdef CDB_RR_EN
    check("rr_slot7_served", cnt7 >= 3, 1);
`else
    check("fixed_slot7_starved", cnt7, 0);
`endif
    clear_inputs();
    for (int c = 0; c < 10; c++) tick();

    // Backpressure on slot 2
    for (int i = 1; i <= N; i++) put(i, 32'h11 * i, 5'(i), 1'b1);
    tick();
    clear_inputs();
    if (m_winner() == 2) begin
      put(2, 32'h22, 5'd2, 1'b1);
      tick();
      clear_inputs();
    end
    put(2, 32'hBEEF, 5'd2, 1'b1);
    check("bp_ready2", fu_ready[2], 0);
    tick();
    clear_inputs();
    check("bp_overflow", overflow, 1);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (CDB_result[2]) begin
        check("bp_keep", CDB_data, 32'h22);
        seen = 1;
      end
    end
    check("bp_seen", seen, 1);

    // x0 destination and no-writeback
    put(3, 32'h30, 5'd0, 1'b1);
    put(4, 32'h40, 5'd9, 1'b0);
    tick();
    clear_inputs();
    nb = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (CDB_result != 0) begin
        nb++;
        check("x0_wen", register_write_en, 0);
      end
    end
    check("x0_count", nb, 2);

    // Reset mid-operation
    put(1, 32'h1111, 5'd1, 1'b1);
    put(4, 32'h4444, 5'd4, 1'b1);
    put(5, 32'h5555, 5'd5, 1'b1);
    tick();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_result", CDB_result, 0);
    check("mid_rst_data", CDB_data, 0);
    check("mid_rst_addr", CDB_addr, 0);
    check("mid_rst_wen", register_write_en, 0);
    check("mid_rst_ovf", overflow, 0);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("mid_rst_quiet", CDB_result, 0);
    end
    put(4, 32'h44, 5'd4, 1'b1);
    tick();
    clear_inputs();
    tick();
    check("post_rst_grant", CDB_result, 32'h010);
    check("post_rst_data", CDB_data, 32'h44);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 1; i <= N; i++) begin
        in_done[i] = ($urandom_range(0, 99) < 30);
        in_data[i] = $urandom;
        in_rd[i]   = 5'($urandom_range(0, 31));
        in_wb[i]   = 1'($urandom_range(0, 1));
      end
      junk0 = 1'($urandom_range(0, 1));
      rst   = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    junk0 = 1'b0;
    clear_inputs();
    for (int c = 0; c < 12; c++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
